// File: rtl/addsub_arbiter_pkg.sv
// Shared definitions for the add/sub arbiter: FSM state encoding,
// requester identifiers, operation encodings and counter sizing.
package addsub_arbiter_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Requester identifier
    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_t;

    // Operation encodings
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Overflow event counter sizing
    localparam int unsigned CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage : addsub_arbiter_pkg

// File: rtl/addsub_arbiter_core.sv
// Combinational signed add/subtract with overflow detection.
// Ports:
//   a, b      - signed operands (W bits)
//   op        - OP_ADD or OP_SUB
//   result    - low W bits of the W+1-bit result (wraps)
//   overflow  - signed overflow of result
module addsub_core
    import addsub_arbiter_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic                op,
    output logic signed [W-1:0] result,
    output logic                overflow
);

    logic signed [W:0] a_ext;
    logic signed [W:0] b_ext;
    logic signed [W:0] sum;

    // One extra bit makes overflow visible as disagreement of the top two bits
    always_comb begin
        a_ext    = {a[W-1], a};
        b_ext    = {b[W-1], b};
        sum      = (op == OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);
        result   = sum[W-1:0];
        overflow = sum[W] ^ sum[W-1];
    end

endmodule : addsub_core

// File: rtl/addsub_arbiter.sv
// Two-requester arbiter time-sharing one add/sub datapath.
// Round-robin grant in IDLE, one-cycle compute in EXEC, response held in
// RESP until the owning requester consumes it.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   reqN_valid/a/b/op/ready   - request channel of requester N
//   rspN_valid/ready          - response channel of requester N
//   rsp_result, rsp_overflow  - shared registered result and overflow flag
//   busy                      - FSM not in IDLE
//   ovf_count                 - saturating count of overflowing operations
module addsub_arbiter
    import addsub_arbiter_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic signed [W-1:0]  req0_a,
    input  logic signed [W-1:0]  req0_b,
    input  logic                 req0_op,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic signed [W-1:0]  req1_a,
    input  logic signed [W-1:0]  req1_b,
    input  logic                 req1_op,
    output logic                 req1_ready,
    output logic                 rsp0_valid,
    input  logic                 rsp0_ready,
    output logic                 rsp1_valid,
    input  logic                 rsp1_ready,
    output logic signed [W-1:0]  rsp_result,
    output logic                 rsp_overflow,
    output logic                 busy,
    output logic [CNT_W-1:0]     ovf_count
);

    state_t              state;
    state_t              state_next;
    req_id_t             last;
    req_id_t             owner;
    req_id_t             grant_id;
    logic                grant_valid;
    logic                rsp_handshake;
    logic signed [W-1:0] a_q;
    logic signed [W-1:0] b_q;
    logic                op_q;
    logic signed [W-1:0] core_result;
    logic                core_overflow;

    // Round-robin grant: on a tie the requester not served last wins
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        grant_id    = REQ0;
        if (req0_valid && req1_valid) begin
            if (last == REQ0) begin
                grant_id = REQ1;
            end
        end else if (req1_valid) begin
            grant_id = REQ1;
        end
    end

    // Only the owner's rsp_ready can complete a response
    always_comb begin
        rsp_handshake = (owner == REQ0) ? rsp0_ready : rsp1_ready;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (grant_valid)   state_next = ST_EXEC;
            ST_EXEC:                    state_next = ST_RESP;
            ST_RESP: if (rsp_handshake) state_next = ST_IDLE;
            default:                    state_next = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        busy       = (state != ST_IDLE);
        if (state == ST_IDLE && grant_valid) begin
            req0_ready = (grant_id == REQ0);
            req1_ready = (grant_id == REQ1);
        end
        if (state == ST_RESP) begin
            rsp0_valid = (owner == REQ0);
            rsp1_valid = (owner == REQ1);
        end
    end

    addsub_core #(
        .W (W)
    ) u_core (
        .a        (a_q),
        .b        (b_q),
        .op       (op_q),
        .result   (core_result),
        .overflow (core_overflow)
    );

    // Operand capture, result register, fairness pointer and overflow counter
    always_ff @(posedge clk) begin
        if (rst) begin
            last         <= REQ1;
            owner        <= REQ0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= OP_ADD;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            ovf_count    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        owner <= grant_id;
                        if (grant_id == REQ0) begin
                            a_q  <= req0_a;
                            b_q  <= req0_b;
                            op_q <= req0_op;
                        end else begin
                            a_q  <= req1_a;
                            b_q  <= req1_b;
                            op_q <= req1_op;
                        end
                    end
                end
                ST_EXEC: begin
                    rsp_result   <= core_result;
                    rsp_overflow <= core_overflow;
                    if (core_overflow && (ovf_count != CNT_MAX)) begin
                        ovf_count <= ovf_count + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_handshake) begin
                        last <= owner;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : addsub_arbiter

// File: tb/tb_addsub_arbiter.sv
// Directed self-checking bench for addsub_arbiter (W = 8).
module tb_addsub_arbiter;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_op, req1_op;
    logic         req0_ready, req1_ready;
    logic         rsp0_valid, rsp1_valid;
    logic         rsp0_ready, rsp1_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_overflow;
    logic         busy;
    logic [7:0]   ovf_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    addsub_arbiter #(
        .W (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req0_op      (req0_op),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .req1_op      (req1_op),
        .req1_ready   (req1_ready),
        .rsp0_valid   (rsp0_valid),
        .rsp0_ready   (rsp0_ready),
        .rsp1_valid   (rsp1_valid),
        .rsp1_ready   (rsp1_ready),
        .rsp_result   (rsp_result),
        .rsp_overflow (rsp_overflow),
        .busy         (busy),
        .ovf_count    (ovf_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle, leaving time just after the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // One complete transaction from requester id with fixed latency checks
    task automatic do_txn(input string tag, input int id, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic op,
                          input logic [W-1:0] exp_res, input logic exp_ovf);
        if (id == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end
        #1;
        check({tag, "_ready"},       (id == 0) ? req0_ready : req1_ready, 32'd1);
        check({tag, "_other_ready"}, (id == 0) ? req1_ready : req0_ready, 32'd0);
        tick();
        // Scramble inputs after acceptance; the operation must be unaffected
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 8'h5A; req0_b = 8'hA5; req0_op = ~op;
        req1_a = 8'h5A; req1_b = 8'hA5; req1_op = ~op;
        check({tag, "_exec_busy"},  busy, 32'd1);
        check({tag, "_exec_valid"}, (id == 0) ? rsp0_valid : rsp1_valid, 32'd0);
        tick();
        check({tag, "_rsp_valid"},  (id == 0) ? rsp0_valid : rsp1_valid, 32'd1);
        check({tag, "_rsp_other"},  (id == 0) ? rsp1_valid : rsp0_valid, 32'd0);
        check({tag, "_result"},     rsp_result, 32'(exp_res));
        check({tag, "_overflow"},   rsp_overflow, 32'(exp_ovf));
        if (id == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        check({tag, "_done_busy"},  busy, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ngrant;
        int nhs;

        // Reset values
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        check("rst_busy",      busy, 32'd0);
        check("rst_rsp0",      rsp0_valid, 32'd0);
        check("rst_rsp1",      rsp1_valid, 32'd0);
        check("rst_result",    rsp_result, 32'd0);
        check("rst_overflow",  rsp_overflow, 32'd0);
        check("rst_ovf_count", ovf_count, 32'd0);
        check("rst_ready0",    req0_ready, 32'd0);
        check("rst_ready1",    req1_ready, 32'd0);
        rst = 1'b0;

        // Basic arithmetic
        do_txn("add0", 0, 8'd15, 8'd20, 1'b0, 8'd35, 1'b0);
        check("add0_ovf_count", ovf_count, 32'd0);
        do_txn("sub1", 1, 8'd10, 8'hEC, 1'b1, 8'h1E, 1'b0);   // 10 - (-20) = 30
        do_txn("ovf1", 1, 8'd100, 8'd30, 1'b0, 8'h82, 1'b1);  // 130 wraps to -126
        check("ovf1_ovf_count", ovf_count, 32'd1);

        // Round-robin with both requesters continuously valid
        do_reset();
        req0_valid = 1'b1; req0_a = 8'd1; req0_b = 8'd1;
        req1_valid = 1'b1; req1_a = 8'd2; req1_b = 8'd2;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        ngrant = 0;
        for (int cyc = 0; cyc < 40 && ngrant < 4; cyc++) begin
            #1;
            if (req0_ready || req1_ready) begin
                check("rr_one_hot", 32'(req0_ready & req1_ready), 32'd0);
                check($sformatf("rr_grant%0d", ngrant), 32'(req1_ready), 32'(ngrant % 2));
                ngrant++;
            end
            tick();
        end
        check("rr_count", ngrant, 32'd4);

        // Response backpressure on requester 0 while requester 1 waits
        do_reset();
        req0_valid = 1'b1; req0_a = 8'd5; req0_b = 8'd3; req0_op = 1'b1;
        req1_valid = 1'b1; req1_a = 8'd9; req1_b = 8'd9; req1_op = 1'b0;
        #1;
        check("bp_ready0", req0_ready, 32'd1);
        check("bp_ready1", req1_ready, 32'd0);
        tick();
        req0_valid = 1'b0;
        tick();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b1;    // non-owner ready must be ignored
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_valid%0d", i),  rsp0_valid, 32'd1);
            check($sformatf("bp_result%0d", i), rsp_result, 32'd2);
            check($sformatf("bp_busy%0d", i),   busy, 32'd1);
            check($sformatf("bp_req1_%0d", i),  req1_ready, 32'd0);
            tick();
        end
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        #1;
        check("bp_after_busy",  busy, 32'd0);
        check("bp_after_req1",  req1_ready, 32'd1);
        idle_inputs();
        tick();

        // Reset during EXEC: no counter update
        do_reset();
        req0_valid = 1'b1; req0_a = 8'h9C; req0_b = 8'hE2; req0_op = 1'b0;
        tick();
        req0_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rexec_busy",      busy, 32'd0);
        check("rexec_ovf_count", ovf_count, 32'd0);
        check("rexec_result",    rsp_result, 32'd0);
        check("rexec_rsp0",      rsp0_valid, 32'd0);

        // Reset during RESP: -100 + -30 = -130 wraps to 126 with overflow
        req0_valid = 1'b1; req0_a = 8'h9C; req0_b = 8'hE2; req0_op = 1'b0;
        tick();
        req0_valid = 1'b0;
        tick();
        check("rresp_valid",     rsp0_valid, 32'd1);
        check("rresp_result",    rsp_result, 32'h7E);
        check("rresp_overflow",  rsp_overflow, 32'd1);
        check("rresp_ovf_pre",   ovf_count, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rresp_rsp0",      rsp0_valid, 32'd0);
        check("rresp_rsp1",      rsp1_valid, 32'd0);
        check("rresp_ovf_count", ovf_count, 32'd0);
        check("rresp_busy",      busy, 32'd0);
        check("rresp_ovf_flag",  rsp_overflow, 32'd0);

        // Counter saturation: 260 overflowing operations
        do_reset();
        req0_valid = 1'b1; req0_a = 8'd127; req0_b = 8'd1; req0_op = 1'b0;
        rsp0_ready = 1'b1;
        nhs = 0;
        for (int cyc = 0; cyc < 1000 && nhs < 260; cyc++) begin
            #1;
            if (rsp0_valid && rsp0_ready) begin
                nhs++;
                if (nhs == 254) check("sat_254", ovf_count, 32'd254);
                if (nhs == 256) check("sat_256", ovf_count, 32'd255);
                if (nhs == 260) begin
                    check("sat_result",   rsp_result, 32'h80);
                    check("sat_overflow", rsp_overflow, 32'd1);
                    req0_valid = 1'b0;
                end
            end
            tick();
        end
        check("sat_ops",   nhs, 32'd260);
        check("sat_final", ovf_count, 32'd255);
        check("sat_busy",  busy, 32'd0);
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_addsub_arbiter
